// File: rtl/wordle_score_ctrl.sv
// Wordle guess scorer: computes per-slot colours with duplicate-letter rules
// and streams them to the colour store over a valid/ready write port.
module wordle_score_ctrl #(
  parameter int unsigned NUM_ROWS = 6,
  parameter int unsigned LETTER_W = 8
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic [5*LETTER_W-1:0] guess,
  input  logic [5*LETTER_W-1:0] answer,
  output logic                  busy,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [2:0]            wr_row,
  output logic [2:0]            wr_col,
  output logic [1:0]            wr_color,
  output logic                  done,
  output logic                  err,
  output logic                  win,
  output logic                  lose,
  output logic [2:0]            row
);

  typedef enum logic [2:0] {StIdle, StGreen, StYellow, StWrite, StDone} state_e;

  localparam logic [2:0] LastRow = 3'(NUM_ROWS - 1);

  state_e state_q, state_d;

  logic [4:0][LETTER_W-1:0] g_q, a_q;
  logic [4:0][1:0]          color_q;
  logic [4:0]               used_q, found_q;
  logic [2:0]               i_q, j_q, k_q;
  logic [2:0]               row_q;
  logic                     win_q, lose_q, err_q;
  logic                     guess_ok, accept, all_green;

  // Every guess byte must be an uppercase ASCII letter.
  always_comb begin
    guess_ok = 1'b1;
    for (int s = 0; s < 5; s++) begin
      if (guess[s*LETTER_W +: LETTER_W] < LETTER_W'('h41) ||
          guess[s*LETTER_W +: LETTER_W] > LETTER_W'('h5A)) begin
        guess_ok = 1'b0;
      end
    end
  end

  assign accept    = (state_q == StIdle) && start && !clear && !win_q && !lose_q;
  assign all_green = (color_q == {5{2'b10}});

  // State register.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear aborts from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept && guess_ok) state_d = StGreen;
      StGreen:  if (i_q == 3'd4) state_d = StYellow;
      StYellow: if (i_q == 3'd4 && j_q == 3'd4) state_d = StWrite;
      StWrite:  if (wr_ready && k_q == 3'd4) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (clear) state_d = StIdle;
  end

  // Scoring datapath, slot counters and game status.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q     <= '0;
      a_q     <= '0;
      color_q <= '0;
      used_q  <= '0;
      found_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (clear) begin
      color_q <= '0;
      used_q  <= '0;
      found_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !guess_ok;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            for (int s = 0; s < 5; s++) begin
              g_q[s] <= guess[(4-s)*LETTER_W +: LETTER_W];
              a_q[s] <= answer[(4-s)*LETTER_W +: LETTER_W];
            end
            color_q <= '0;
            used_q  <= '0;
            found_q <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
          end
        end
        StGreen: begin
          if (g_q[i_q] == a_q[i_q]) begin
            color_q[i_q] <= 2'b10;
            used_q[i_q]  <= 1'b1;
          end
          i_q <= (i_q == 3'd4) ? 3'd0 : i_q + 3'd1;
        end
        StYellow: begin
          // found_q stops a guess slot claiming a second answer letter.
          if (color_q[i_q] != 2'b10 && !found_q[i_q] && !used_q[j_q] &&
              g_q[i_q] == a_q[j_q]) begin
            color_q[i_q] <= 2'b01;
            used_q[j_q]  <= 1'b1;
            found_q[i_q] <= 1'b1;
          end
          if (j_q == 3'd4) begin
            j_q <= 3'd0;
            i_q <= (i_q == 3'd4) ? 3'd0 : i_q + 3'd1;
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
        StWrite: begin
          if (wr_ready) k_q <= k_q + 3'd1;
        end
        StDone: begin
          win_q  <= all_green;
          lose_q <= !all_green && (row_q == LastRow);
          if (!all_green && row_q < LastRow) row_q <= row_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; write fields are zero outside WRITE.
  always_comb begin
    busy     = (state_q != StIdle);
    wr_valid = (state_q == StWrite);
    wr_row   = wr_valid ? row_q : 3'd0;
    wr_col   = wr_valid ? k_q : 3'd0;
    wr_color = wr_valid ? color_q[k_q] : 2'b00;
    done     = (state_q == StDone);
    err      = err_q;
    win      = win_q;
    lose     = lose_q;
    row      = row_q;
  end

endmodule

// File: tb/tb_wordle_score_ctrl.sv
// Directed bench for wordle_score_ctrl: table of scored guesses plus
// sequences for stall, error, abort, reset and end-of-game corners.
module tb_wordle_score_ctrl;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [39:0] guess = '0;
  logic [39:0] answer = '0;
  logic        wr_ready = 1'b1;
  logic        busy, wr_valid, done, err, win, lose;
  logic [2:0]  wr_row, wr_col, row;
  logic [1:0]  wr_color;

  wordle_score_ctrl #(.NUM_ROWS(6), .LETTER_W(8)) dut (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .start    (start),
    .guess    (guess),
    .answer   (answer),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_color (wr_color),
    .done     (done),
    .err      (err),
    .win      (win),
    .lose     (lose),
    .row      (row)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [39:0] g;
    logic [39:0] a;
    logic [9:0]  colors;  // slot0 in [9:8]
    logic        win;
    logic [2:0]  row;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Starts one guess and follows it to done, stalling wr_ready on one column.
  task automatic run_guess(input logic [39:0] g, input logic [39:0] a, input int stall_col,
                           input int stall_n, input logic [2:0] exp_row,
                           output logic [9:0] colors, output int lat);
    int nwr, left, cc;
    logic stalling;
    logic [2:0] h_row, h_col;
    logic [1:0] h_color;
    colors = '0;
    lat = -1;
    nwr = 0;
    left = stall_n;
    stalling = 1'b0;
    h_row = '0;
    h_col = '0;
    h_color = '0;
    guess = g;
    answer = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    for (int c = 1; c <= 200; c++) begin
      if (wr_valid && int'(wr_col) == stall_col && left > 0) begin
        if (!stalling) begin
          h_row = wr_row;
          h_col = wr_col;
          h_color = wr_color;
          stalling = 1'b1;
        end else begin
          check("stall_stable", {24'd0, wr_row, wr_col, wr_color}, {24'd0, h_row, h_col, h_color});
        end
        wr_ready = 1'b0;
        left--;
      end else begin
        if (stalling) begin
          check("stall_release", {24'd0, wr_row, wr_col, wr_color},
                {24'd0, h_row, h_col, h_color});
          stalling = 1'b0;
        end
        wr_ready = 1'b1;
      end
      if (wr_valid && wr_ready) begin
        cc = int'(wr_col);
        check("wr_order", {29'd0, wr_col}, nwr);
        check("wr_row", {29'd0, wr_row}, {29'd0, exp_row});
        if (cc <= 4) colors[(4-cc)*2 +: 2] = wr_color;
        nwr++;
      end
      tick();
      if (done) begin
        lat = c;
        break;
      end
    end
    wr_ready = 1'b1;
    check("done_seen", {31'd0, lat > 0}, 32'd1);
    check("n_writes", nwr, 32'd5);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [9:0] colors;
    int lat;
    logic seen_done;

    vecs[0] = '{g: "CRANE", a: "CRANE", colors: 10'b10_10_10_10_10, win: 1'b1, row: 3'd0};
    vecs[1] = '{g: "PAPAL", a: "APPLE", colors: 10'b01_01_10_00_01, win: 1'b0, row: 3'd1};
    vecs[2] = '{g: "BBBBB", a: "CRANE", colors: 10'b00_00_00_00_00, win: 1'b0, row: 3'd1};
    vecs[3] = '{g: "BABES", a: "ABBEY", colors: 10'b01_01_10_10_00, win: 1'b0, row: 3'd1};
    vecs[4] = '{g: "ALLOY", a: "LLAMA", colors: 10'b01_10_01_00_00, win: 1'b0, row: 3'd1};
    vecs[5] = '{g: "EEEEE", a: "CRANE", colors: 10'b00_00_00_00_10, win: 1'b0, row: 3'd1};

    #12;
    check("reset_outs", {23'd0, busy, wr_valid, done, err, win, lose, row},
          32'd0);
    check("reset_wr", {27'd0, wr_row, wr_color}, 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[n]) begin
      do_clear();
      run_guess(vecs[n].g, vecs[n].a, -1, 0, 3'd0, colors, lat);
      check($sformatf("colors_%0d", n), {22'd0, colors}, {22'd0, vecs[n].colors});
      check($sformatf("latency_%0d", n), lat, 32'd35);
      check($sformatf("win_%0d", n), {31'd0, win}, {31'd0, vecs[n].win});
      check($sformatf("lose_%0d", n), {31'd0, lose}, 32'd0);
      check($sformatf("row_%0d", n), {29'd0, row}, {29'd0, vecs[n].row});
    end

    // After a win, further starts are ignored.
    do_clear();
    run_guess("CRANE", "CRANE", -1, 0, 3'd0, colors, lat);
    guess = "BBBBB";
    start = 1'b1;
    tick();
    start = 1'b0;
    check("win_ignore_busy", {31'd0, busy}, 32'd0);
    check("win_ignore_err", {31'd0, err}, 32'd0);
    check("win_sticky", {28'd0, win, row}, {28'd0, 1'b1, 3'd0});

    // Six misses lose the game; row saturates at 5.
    do_clear();
    for (int r = 0; r < 6; r++) begin
      run_guess("BBBBB", "CRANE", -1, 0, 3'(r), colors, lat);
      check("miss_colors", {22'd0, colors}, 32'd0);
      check("miss_lose", {31'd0, lose}, (r == 5) ? 32'd1 : 32'd0);
      check("miss_row", {29'd0, row}, (r == 5) ? 32'd5 : 32'(r + 1));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lose_ignore_busy", {31'd0, busy}, 32'd0);
    tick();
    check("lose_ignore_busy2", {31'd0, busy}, 32'd0);

    // Three stalled cycles on column 2.
    do_clear();
    run_guess("PAPAL", "APPLE", 2, 3, 3'd0, colors, lat);
    check("stall_colors", {22'd0, colors}, {22'd0, 10'b01_01_10_00_01});
    check("stall_latency", lat, 32'd38);
    check("stall_row", {29'd0, row}, 32'd1);

    // Invalid letter: err pulse only.
    guess = "CR NE";
    answer = "CRANE";
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", {29'd0, err, busy, wr_valid}, 32'b100);
    tick();
    check("err_drop", {29'd0, err, busy, wr_valid}, 32'd0);
    check("err_row", {29'd0, row}, 32'd1);

    // Asynchronous reset mid-YELLOW.
    guess = "BBBBB";
    answer = "CRANE";
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("yellow_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset", {23'd0, busy, wr_valid, done, err, win, lose, row}, 32'd0);
    #2;
    reset_n = 1'b1;
    tick();

    // Clear during WRITE after column 1 handshake.
    run_guess("BBBBB", "CRANE", -1, 0, 3'd0, colors, lat);
    check("pre_clear_row", {29'd0, row}, 32'd1);
    guess = "CRANE";
    answer = "CRANE";
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (wr_valid && wr_col == 3'd2) break;
      tick();
    end
    check("reach_col2", {28'd0, wr_valid, wr_col}, {28'd0, 1'b1, 3'd2});
    do_clear();
    check("abort_outs", {27'd0, wr_valid, busy, row}, 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || wr_valid) seen_done = 1'b1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    run_guess("CRANE", "CRANE", -1, 0, 3'd0, colors, lat);
    check("after_abort_colors", {22'd0, colors}, {22'd0, 10'b10_10_10_10_10});
    check("after_abort_lat", lat, 32'd35);
    check("after_abort_win", {28'd0, win, row}, {28'd0, 1'b1, 3'd0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
